irrigation_controller: RTL
==========================

IRRIGATION_CONTROLLER -- requirements
Module: irrigation_controller

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock cycles per 1 s tick.
REQ-002 Parameter MIN_ON_S, default 5, minimum irrigation time in seconds.
REQ-003 Parameter MAX_ON_S, default 60, maximum irrigation time in seconds; MAX_ON_S > MIN_ON_S.
REQ-004 Parameter COOL_S, default 10, post-irrigation lockout in seconds.
REQ-005 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 soil_humid  input  1  asynchronous; 1 = soil wet.
REQ-009 air_humid  input  1  asynchronous; 1 = air humid.
REQ-010 high_temp  input  1  asynchronous; 1 = temperature above threshold.
REQ-011 tank_probe  input  3  asynchronous tank probes, bit0 lowest; 1 = submerged.
REQ-012 irrigation_status  output  2  00 idle, 01 drip, 10 sprinkler, 11 error; feeds the LED display stage.
REQ-013 water_tank_level  output  2  0 empty .. 3 full; feeds the LED display stage.
REQ-014 valve_drip  output  1  drip valve drive.
REQ-015 valve_sprinkler  output  1  sprinkler valve drive.

Function
REQ-016 Every asynchronous input SHALL pass a 2-flop synchronizer before use.
REQ-017 Prescaler SHALL count 0..CLK_HZ-1 and emit a one-cycle tick when count equals CLK_HZ-1, then wrap to 0.
REQ-018 Each synchronized input SHALL update its filtered copy only after 3 consecutive ticks sampling the same new value.
REQ-019 Filtered tank_probe codes 000/001/011/111 SHALL map to level 0/1/2/3; any other code is invalid, and the level output holds its last valid value.
REQ-020 FSM states: IDLE, DRIP, SPRINKLER, COOLDOWN, ERROR; transitions evaluated on tick only.
REQ-021 Any state -> ERROR when filtered tank code is invalid; highest priority.
REQ-022 ERROR -> IDLE on the first tick with a valid code; the on-timer is cleared.
REQ-023 IDLE -> SPRINKLER when soil_humid=0, high_temp=1, air_humid=0 and level>=2.
REQ-024 IDLE -> DRIP when soil_humid=0, the sprinkler condition is false, and level>=1.
REQ-025 IDLE SHALL hold when soil_humid=1 or level=0.
REQ-026 On entry to DRIP or SPRINKLER, the on-timer SHALL load 0 and increment per tick, saturating at MAX_ON_S.
REQ-027 DRIP/SPRINKLER -> COOLDOWN on the first applicable condition, in priority order: level=0 (immediate, ignores MIN_ON_S); on-timer=MAX_ON_S; soil_humid=1 and on-timer>=MIN_ON_S.
REQ-028 No transition between DRIP and SPRINKLER directly; a mode change requires COOLDOWN.
REQ-029 COOLDOWN SHALL last exactly COOL_S ticks, then go to IDLE.
REQ-030 irrigation_status SHALL be registered: 01 in DRIP, 10 in SPRINKLER, 11 in ERROR, and 00 otherwise.
REQ-031 valve_drip SHALL be 1 only in DRIP and valve_sprinkler only in SPRINKLER; both SHALL never be 1 together.
REQ-032 All outputs SHALL change in the cycle after the tick that caused the transition.

Reset
REQ-033 While rst_n=0: FSM=IDLE; prescaler, on-timer, cooldown counter and filter counters=0; filtered soil_humid=1; other filtered inputs=0; outputs all 0.
REQ-034 Reset assertion mid-irrigation SHALL close both valves asynchronously, with no wait for clk.
REQ-035 After rst_n release, the first tick SHALL occur CLK_HZ cycles later.

Verification (CLK_HZ=4, MIN_ON_S=2, MAX_ON_S=5, COOL_S=3)
REQ-036 tank_probe=011, soil_humid=0, others 0, held -> status 01 and valve_drip=1 after 3 filter ticks plus the sync/decision ticks; water_tank_level=2.
REQ-037 tank_probe=111, soil_humid=0, high_temp=1, air_humid=0 -> status 10; soil_humid->1 at on-timer=1 -> sprinkler holds until on-timer=2, then status 00 for 3 ticks, then IDLE.
REQ-038 DRIP with soil_humid held 0 -> COOLDOWN at on-timer=5; no re-entry before 3 ticks have elapsed.
REQ-039 DRIP, tank_probe->000 -> valve_drip=0 one cycle after the 3rd filtered tick, regardless of MIN_ON_S; water_tank_level=0.
REQ-040 tank_probe=101 for 3 ticks -> status 11, both valves 0, water_tank_level holds its prior value; probe->011 -> IDLE on the next tick.
REQ-041 rst_n pulsed low during SPRINKLER -> valves 0 immediately; status 00; restart timing per REQ-035.

Source files
------------

// File: rtl/irrigation_controller.sv
// rtl/irrigation_controller.sv - tick-driven drip/sprinkler irrigation controller
// Inputs are synchronized and debounced over three 1 s ticks before the FSM acts on them.
module irrigation_controller #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int MIN_ON_S = 5,
    parameter int MAX_ON_S = 60,
    parameter int COOL_S   = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       soil_humid,
    input  logic       air_humid,
    input  logic       high_temp,
    input  logic [2:0] tank_probe,
    output logic [1:0] irrigation_status,
    output logic [1:0] water_tank_level,
    output logic       valve_drip,
    output logic       valve_sprinkler
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int TW = $clog2(MAX_ON_S + 1);
    localparam int CW = (COOL_S > 1) ? $clog2(COOL_S) : 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [TW-1:0] ON_MAX   = TW'(MAX_ON_S);
    localparam logic [TW-1:0] ON_MIN   = TW'(MIN_ON_S);
    localparam logic [CW-1:0] COOL_END = CW'(COOL_S - 1);

    // Bit map: 0 soil, 1 air, 2 temp, 5:3 tank probes; soil idles "wet" so nothing starts from reset.
    localparam logic [5:0] IN_RESET = 6'b000001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIP,
        S_SPRINKLER,
        S_COOLDOWN,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      sync1_q, sync2_q;
    logic [5:0]      filt_q, filt_d;
    logic [5:0][1:0] fcnt_q, fcnt_d;
    logic [PW-1:0]   pre_q;
    logic [TW-1:0]   on_q, on_d;
    logic [CW-1:0]   cool_q, cool_d;
    logic            tick;
    logic            tank_ok;
    logic [1:0]      lvl_d;
    logic            soil_f, air_f, temp_f;

    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IN_RESET;
            sync2_q <= IN_RESET;
            filt_q  <= IN_RESET;
            fcnt_q  <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= {tank_probe, high_temp, air_humid, soil_humid};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            fcnt_q  <= fcnt_d;
            pre_q   <= tick ? '0 : pre_q + PW'(1);
        end
    end

    // A differing sample on three consecutive ticks commits the new value; any agreeing sample restarts.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (tick) begin
            for (int i = 0; i < 6; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_d[i] = 2'd0;
                end else if (fcnt_q[i] == 2'd2) begin
                    filt_d[i] = sync2_q[i];
                    fcnt_d[i] = 2'd0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 2'd1;
                end
            end
        end
    end

    // Decisions use the value being committed on this tick so the FSM reacts on the same tick.
    always_comb begin
        tank_ok = 1'b1;
        lvl_d   = 2'd0;
        case (filt_d[5:3])
            3'b000:  lvl_d = 2'd0;
            3'b001:  lvl_d = 2'd1;
            3'b011:  lvl_d = 2'd2;
            3'b111:  lvl_d = 2'd3;
            default: tank_ok = 1'b0;
        endcase
    end

    assign soil_f = filt_d[0];
    assign air_f  = filt_d[1];
    assign temp_f = filt_d[2];

    always_comb begin
        state_d = state_q;
        on_d    = on_q;
        cool_d  = cool_q;
        if (tick) begin
            if (!tank_ok) begin
                state_d = S_ERROR;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!soil_f && lvl_d != 2'd0) begin
                            on_d    = '0;
                            state_d = (temp_f && !air_f && lvl_d >= 2'd2) ? S_SPRINKLER : S_DRIP;
                        end
                    end
                    S_DRIP, S_SPRINKLER: begin
                        if (lvl_d == 2'd0 || on_q == ON_MAX || (soil_f && on_q >= ON_MIN)) begin
                            state_d = S_COOLDOWN;
                            cool_d  = '0;
                        end else begin
                            on_d = on_q + TW'(1);
                        end
                    end
                    S_COOLDOWN: begin
                        if (cool_q == COOL_END) state_d = S_IDLE;
                        else cool_d = cool_q + CW'(1);
                    end
                    S_ERROR: begin
                        state_d = S_IDLE;
                        on_d    = '0;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Outputs are registered from the next state; the async reset closes the valves without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            on_q              <= '0;
            cool_q            <= '0;
            irrigation_status <= 2'b00;
            water_tank_level  <= 2'd0;
            valve_drip        <= 1'b0;
            valve_sprinkler   <= 1'b0;
        end else begin
            state_q         <= state_d;
            on_q            <= on_d;
            cool_q          <= cool_d;
            valve_drip      <= (state_d == S_DRIP);
            valve_sprinkler <= (state_d == S_SPRINKLER);
            case (state_d)
                S_DRIP:      irrigation_status <= 2'b01;
                S_SPRINKLER: irrigation_status <= 2'b10;
                S_ERROR:     irrigation_status <= 2'b11;
                default:     irrigation_status <= 2'b00;
            endcase
            if (tank_ok) water_tank_level <= lvl_d;
        end
    end

endmodule
